// File: rtl/dda_host_ctrl.sv
// Byte-command UART host for the Lorenz DDA core: loads the parameter file atomically,
// gates/re-initialises the DDA, and returns ACK/NAK replies and framed x/y/z snapshots.
module dda_host_ctrl #(
  parameter int                    REG_SIZE    = 14,
  parameter int                    OUT_SIZE    = 6,
  parameter logic [8*REG_SIZE-1:0] PARAM_INIT  = 112'hC000_14CD_7240_6A00_5555_7300_0400,
  parameter int                    TIMEOUT_CYC = 24000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic [8*OUT_SIZE-1:0] state_in,
  output logic [8*REG_SIZE-1:0] params,
  output logic                  dda_en,
  output logic                  dda_init
);
  localparam int IDX_W    = $clog2(REG_SIZE);
  localparam int TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int FRM_SIZE = OUT_SIZE + 1;
  localparam int CNT_W    = $clog2(FRM_SIZE);

  localparam logic [7:0] CMD_W     = 8'h57;
  localparam logic [7:0] CMD_R     = 8'h52;
  localparam logic [7:0] CMD_S     = 8'h53;
  localparam logic [7:0] CMD_I     = 8'h49;
  localparam logic [7:0] CMD_D     = 8'h44;
  localparam logic [7:0] CMD_T     = 8'h54;
  localparam logic [7:0] BYTE_ACK  = 8'h06;
  localparam logic [7:0] BYTE_NAK  = 8'h15;
  localparam logic [7:0] BYTE_SYNC = 8'hA5;

  typedef enum logic {P_IDLE, P_PAYLOAD} p_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_HOLD, TX_WAIT} tx_state_t;

  p_state_t              p_state_reg, p_state_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [TMR_W-1:0]      timer_reg;
  logic [8*REG_SIZE-1:0] shadow_reg, shadow_next, params_reg;
  logic                  dda_en_reg, dda_init_reg;
  logic                  payload_wr, commit;
  logic                  set_ack, set_nak, set_dump;
  logic                  cmd_run, cmd_stop, cmd_init, cmd_toggle;

  tx_state_t             tx_state_reg, tx_state_next;
  logic                  ack_pend_reg, nak_pend_reg, dump_pend_reg, stream_reg;
  logic                  sel_nak, sel_ack, sel_frame;
  logic [8*FRM_SIZE-1:0] frame_reg;
  logic [CNT_W-1:0]      tx_cnt_reg, tx_last_reg;
  logic                  tx_start_reg;
  logic [7:0]            tx_byte_reg;

  always_comb begin
    p_state_next = p_state_reg;
    payload_wr   = 1'b0;
    commit       = 1'b0;
    set_ack      = 1'b0;
    set_nak      = 1'b0;
    set_dump     = 1'b0;
    cmd_run      = 1'b0;
    cmd_stop     = 1'b0;
    cmd_init     = 1'b0;
    cmd_toggle   = 1'b0;
    case (p_state_reg)
      P_IDLE: begin
        if (rx_error) set_nak = 1'b1;
        if (rx_valid) begin
          case (rx_byte)
            CMD_W:   p_state_next = P_PAYLOAD;
            CMD_R:   begin cmd_run    = 1'b1; set_ack = 1'b1; end
            CMD_S:   begin cmd_stop   = 1'b1; set_ack = 1'b1; end
            CMD_I:   begin cmd_init   = 1'b1; set_ack = 1'b1; end
            CMD_D:   set_dump = 1'b1;
            CMD_T:   begin cmd_toggle = 1'b1; set_ack = 1'b1; end
            default: set_nak = 1'b1;
          endcase
        end
      end
      P_PAYLOAD: begin
        // A framing error or a stalled sender abandons the whole write; params stay intact.
        if (rx_error || (!rx_valid && timer_reg == TMR_W'(TIMEOUT_CYC - 1))) begin
          set_nak      = 1'b1;
          p_state_next = P_IDLE;
        end else if (rx_valid) begin
          payload_wr = 1'b1;
          if (idx_reg == IDX_W'(REG_SIZE - 1)) begin
            commit       = 1'b1;
            set_ack      = 1'b1;
            p_state_next = P_IDLE;
          end
        end
      end
      default: p_state_next = P_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_SIZE; gi++) begin : g_lane
      assign shadow_next[8*(REG_SIZE-1-gi) +: 8] =
        (payload_wr && idx_reg == IDX_W'(gi)) ? rx_byte : shadow_reg[8*(REG_SIZE-1-gi) +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_reg  <= P_IDLE;
      idx_reg      <= '0;
      timer_reg    <= '0;
      shadow_reg   <= '0;
      params_reg   <= PARAM_INIT;
      dda_en_reg   <= 1'b1;
      dda_init_reg <= 1'b0;
    end else begin
      p_state_reg <= p_state_next;
      shadow_reg  <= shadow_next;
      if (p_state_reg == P_IDLE) idx_reg <= '0;
      else if (payload_wr)       idx_reg <= idx_reg + 1'b1;
      if (p_state_reg == P_IDLE || rx_valid) timer_reg <= '0;
      else                                   timer_reg <= timer_reg + 1'b1;
      // Commit takes the final byte straight from the lane mux so params switch in one edge.
      if (commit) params_reg <= shadow_next;
      if (cmd_run)       dda_en_reg <= 1'b1;
      else if (cmd_stop) dda_en_reg <= 1'b0;
      dda_init_reg <= cmd_init;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    sel_nak       = 1'b0;
    sel_ack       = 1'b0;
    sel_frame     = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (nak_pend_reg)                      sel_nak   = 1'b1;
        else if (ack_pend_reg)                 sel_ack   = 1'b1;
        else if (dump_pend_reg || stream_reg)  sel_frame = 1'b1;
        if (nak_pend_reg || ack_pend_reg || dump_pend_reg || stream_reg) tx_state_next = TX_SEND;
      end
      TX_SEND: tx_state_next = TX_HOLD;
      TX_HOLD: tx_state_next = TX_WAIT;
      TX_WAIT: if (!tx_busy) tx_state_next = (tx_cnt_reg == tx_last_reg) ? TX_IDLE : TX_SEND;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg  <= TX_IDLE;
      ack_pend_reg  <= 1'b0;
      nak_pend_reg  <= 1'b0;
      dump_pend_reg <= 1'b0;
      stream_reg    <= 1'b0;
      frame_reg     <= '0;
      tx_cnt_reg    <= '0;
      tx_last_reg   <= '0;
      tx_start_reg  <= 1'b0;
      tx_byte_reg   <= 8'h00;
    end else begin
      tx_state_reg  <= tx_state_next;
      // A request arriving in the same cycle it is serviced counts as a fresh request.
      nak_pend_reg  <= (nak_pend_reg  & ~sel_nak)   | set_nak;
      ack_pend_reg  <= (ack_pend_reg  & ~sel_ack)   | set_ack;
      dump_pend_reg <= (dump_pend_reg & ~sel_frame) | set_dump;
      if (cmd_toggle) stream_reg <= ~stream_reg;
      tx_start_reg <= (tx_state_reg == TX_SEND);
      if (sel_nak || sel_ack) begin
        frame_reg   <= {(sel_nak ? BYTE_NAK : BYTE_ACK), {(8*OUT_SIZE){1'b0}}};
        tx_last_reg <= '0;
        tx_cnt_reg  <= '0;
      end else if (sel_frame) begin
        frame_reg   <= {BYTE_SYNC, state_in};
        tx_last_reg <= CNT_W'(OUT_SIZE);
        tx_cnt_reg  <= '0;
      end else if (tx_state_reg == TX_SEND) begin
        tx_byte_reg <= frame_reg[8*FRM_SIZE-1 -: 8];
        frame_reg   <= frame_reg << 8;
      end else if (tx_state_reg == TX_WAIT && !tx_busy && tx_cnt_reg != tx_last_reg) begin
        tx_cnt_reg  <= tx_cnt_reg + 1'b1;
      end
    end
  end

  assign params   = params_reg;
  assign dda_en   = dda_en_reg;
  assign dda_init = dda_init_reg;
  assign tx_start = tx_start_reg;
  assign tx_byte  = tx_byte_reg;
endmodule

// File: tb/tb_dda_host_ctrl.sv
// Self-checking bench for dda_host_ctrl: a command-level model predicts params/dda_en/dda_init
// and reply counts; a byte-stream monitor decodes every transmitted byte against the protocol.
module tb_dda_host_ctrl;
  localparam int REG_SIZE = 14;
  localparam int OUT_SIZE = 6;
  localparam int TMO      = 300;
  localparam logic [111:0] PINIT  = 112'hC000_14CD_7240_6A00_5555_7300_0400;
  localparam logic [111:0] PSEQ   = 112'h0102_0304_0506_0708_090A_0B0C_0D0E;
  localparam logic [47:0]  PINNED = 48'h1234_EDCB_4808;

  logic         clk = 1'b0, rst = 1'b1;
  logic         rx_valid = 1'b0, rx_error = 1'b0, tx_busy = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         tx_start, dda_en, dda_init;
  logic [7:0]   tx_byte;
  logic [47:0]  state_in;
  logic [111:0] params;

  always #5 clk = ~clk;

  dda_host_ctrl #(.REG_SIZE(REG_SIZE), .OUT_SIZE(OUT_SIZE), .PARAM_INIT(PINIT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .state_in(state_in),
    .params(params), .dda_en(dda_en), .dda_init(dda_init)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DDA state source: a step counter with self-consistent y/z, or a pinned value.
  logic [15:0] step = 16'h0000;
  int          step_tick = 0;
  logic        freeze = 1'b0;
  always @(posedge clk) begin
    step_tick <= (step_tick == 36) ? 0 : step_tick + 1;
    if (step_tick == 36) step <= step + 16'h0001;
  end
  assign state_in = freeze ? PINNED : {step, ~step, step ^ 16'h5A3C};

  // UART transmitter stand-in: random byte durations, keeps running through rst.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_busy) begin
      if (busy_cnt <= 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= $urandom_range(3, 24);
    end
  end

  // Reference model state.
  logic [111:0] exp_params;
  logic         exp_en, exp_init, exp_stream;
  int           exp_ack = 0, exp_nak = 0, exp_frames = 0;
  logic         m_payload = 1'b0;
  int           m_idx = 0;
  logic [7:0]   m_buf [REG_SIZE];

  // Monitor state.
  int          ack_seen = 0, nak_seen = 0, frames_seen = 0, frame_pos = 0, since_fall = 100;
  logic [47:0] frame_acc, last_frame;
  logic [7:0]  held_byte;
  logic        have_byte = 1'b0, want_sync = 1'b0;
  logic [15:0] fy, fz;

  always @(negedge clk) begin
    if (rst) begin
      frame_pos  = 0;
      have_byte  = 1'b0;
      want_sync  = 1'b0;
      since_fall = 100;
    end else begin
      check("params", params, exp_params);
      check("dda_en", dda_en, exp_en);
      check("dda_init", dda_init, exp_init);
      if (tx_start) begin
        check("start_while_busy", tx_busy, 1'b0);
        check("gap_after_busy", since_fall >= 2, 1'b1);
        if (frame_pos == 0) begin
          if (want_sync) begin
            check("sync_after_nak", tx_byte, 8'hA5);
            want_sync = 1'b0;
          end
          case (tx_byte)
            8'hA5:   frame_pos = 1;
            8'h06:   ack_seen++;
            8'h15:   begin nak_seen++; want_sync = exp_stream; end
            default: check("reply_byte", tx_byte, 8'hA5);
          endcase
        end else begin
          frame_acc = {frame_acc[39:0], tx_byte};
          frame_pos++;
          if (frame_pos == OUT_SIZE + 1) begin
            frame_pos  = 0;
            frames_seen++;
            last_frame = frame_acc;
            fy = ~frame_acc[47:32];
            fz = frame_acc[47:32] ^ 16'h5A3C;
            check("frame_y", frame_acc[31:16], fy);
            check("frame_z", frame_acc[15:0], fz);
          end
        end
        held_byte = tx_byte;
        have_byte = 1'b1;
      end else if (have_byte) begin
        check("tx_byte_hold", tx_byte, held_byte);
      end
      since_fall = tx_busy ? 0 : since_fall + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_payload) begin
      m_buf[m_idx] = b;
      m_idx++;
      if (m_idx == REG_SIZE) begin
        for (int i = 0; i < REG_SIZE; i++) exp_params[8*(REG_SIZE-1-i) +: 8] = m_buf[i];
        exp_ack++;
        m_payload = 1'b0;
      end
    end else begin
      case (b)
        8'h57:   begin m_payload = 1'b1; m_idx = 0; end
        8'h52:   begin exp_en = 1'b1; exp_ack++; end
        8'h53:   begin exp_en = 1'b0; exp_ack++; end
        8'h49:   begin exp_init = 1'b1; exp_ack++; end
        8'h44:   exp_frames++;
        8'h54:   begin exp_stream = ~exp_stream; exp_ack++; end
        default: exp_nak++;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    model_byte(b);
    tick();
    exp_init = 1'b0;
  endtask

  task automatic send_error();
    rx_error = 1'b1;
    tick();
    rx_error  = 1'b0;
    m_payload = 1'b0;
    exp_nak++;
    tick();
  endtask

  task automatic wait_replies(input int budget, input bit strict);
    int n = 0;
    while (!(ack_seen == exp_ack && nak_seen == exp_nak && frames_seen >= exp_frames &&
             frame_pos == 0 && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL reply_wait: ack %0d/%0d nak %0d/%0d frames %0d/%0d", ack_seen, exp_ack,
               nak_seen, exp_nak, frames_seen, exp_frames);
    end
    repeat (60) tick();
    check("ack_count", ack_seen, exp_ack);
    check("nak_count", nak_seen, exp_nak);
    if (strict) check("frame_count", frames_seen, exp_frames);
  endtask

  task automatic wait_frame_pos(input int pos, input string name);
    int n = 0;
    while (frame_pos != pos && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s: frame position %0d never reached", name, pos);
    end
  endtask

  initial begin
    int          snap, f0;
    logic [7:0]  b;
    exp_params = PINIT;
    exp_en     = 1'b1;
    exp_init   = 1'b0;
    exp_stream = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state and quiet idle.
    check("rst_params", params, PINIT);
    check("rst_dda_en", dda_en, 1'b1);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_dda_init", dda_init, 1'b0);
    repeat (30) tick();
    check("idle_no_tx", ack_seen + nak_seen + frames_seen + frame_pos, 0);

    // Dump with a pinned state that changes once the frame is under way.
    freeze = 1'b1;
    send(8'h44);
    wait_frame_pos(1, "dump_start");
    freeze = 1'b0;
    wait_replies(3000, 1'b1);
    check("dump_frame", last_frame, PINNED);

    // Full write 0x01..0x0E.
    send(8'h57);
    for (int i = 1; i <= 13; i++) send(8'(i));
    check("write_partial", params, PINIT);
    send(8'h0E);
    wait_replies(3000, 1'b1);
    check("write_commit", params, PSEQ);

    // Partial write left to time out.
    snap = nak_seen;
    send(8'h57);
    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i));
    repeat (TMO - 12) tick();
    check("no_early_timeout", nak_seen, snap);
    m_payload = 1'b0;
    exp_nak++;
    wait_replies(TMO + 3000, 1'b1);
    check("timeout_params", params, PSEQ);

    // Partial write aborted by a framing error.
    send(8'h57);
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i));
    send_error();
    wait_replies(3000, 1'b1);
    check("rxerr_params", params, PSEQ);

    // Long but legal gap inside a write.
    send(8'h57);
    for (int i = 0; i < 6; i++) send(8'($urandom));
    repeat (TMO - 20) tick();
    for (int i = 6; i < REG_SIZE; i++) send(8'($urandom));
    wait_replies(3000, 1'b1);

    // Stop, init, run.
    snap = ack_seen;
    send(8'h53); wait_replies(3000, 1'b1);
    send(8'h49); wait_replies(3000, 1'b1);
    send(8'h52); wait_replies(3000, 1'b1);
    check("sir_acks", ack_seen - snap, 3);

    // Randomized command mix, one command in flight at a time.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 7))
        0: send(8'h52);
        1: send(8'h53);
        2: send(8'h49);
        3: send(8'h44);
        4: begin
          send(8'h57);
          for (int j = 0; j < REG_SIZE; j++) send(8'($urandom));
        end
        5: begin
          send(8'h57);
          for (int j = 0; j < int'($urandom_range(0, 13)); j++) send(8'($urandom));
          send_error();
        end
        6: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52 || b == 8'h53 || b == 8'h49 || b == 8'h44 || b == 8'h54)
            b = 8'($urandom);
          send(b);
        end
        default: send_error();
      endcase
      wait_replies(3000, 1'b1);
    end

    // Streaming with a NAK injected mid-stream, then stream off.
    send(8'h54);
    wait_replies(3000, 1'b0);
    f0 = frames_seen;
    for (int n = 0; n < 3000 && frames_seen < f0 + 2; n++) tick();
    check("stream_frames", frames_seen >= f0 + 2, 1'b1);
    send(8'h7F);
    wait_replies(3000, 1'b0);
    send(8'h54);
    wait_replies(3000, 1'b0);
    snap = frames_seen;
    repeat (300) tick();
    check("stream_stopped", frames_seen, snap);
    exp_frames = frames_seen;

    // Reset in the middle of a streamed frame.
    send(8'h54);
    wait_frame_pos(3, "mid_frame");
    rst        = 1'b1;
    exp_params = PINIT;
    exp_en     = 1'b1;
    exp_init   = 1'b0;
    exp_stream = 1'b0;
    m_payload  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    snap = ack_seen + nak_seen + frames_seen;
    repeat (300) tick();
    check("rst_no_tx", ack_seen + nak_seen + frames_seen + frame_pos, snap);
    check("rst_tx_start2", tx_start, 1'b0);
    check("rst_params2", params, PINIT);
    check("rst_dda_en2", dda_en, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dda_host_ctrl.md
# dda_host_ctrl

UART host controller for the Lorenz DDA core. It parses a byte-command protocol from the UART receiver and loads the 14-byte parameter file atomically. It also gates and re-initialises the DDA and returns framed snapshots of the x/y/z state through the UART transmitter. It sits between the `uart` instance and the `dda` instance in `tt_um_dda`, replacing the free-running parameter/transmit logic in the top level.

## Interface
Parameters:
- `REG_SIZE`, 14: parameter bytes (icx, icy, icz, sigma, beta, rho, dt; MSB first).
- `OUT_SIZE`, 6: state bytes per frame (x, y, z; MSB first).
- `PARAM_INIT`, `112'hC000_14CD_7240_6A00_5555_7300_0400`: reset contents of the parameter file; byte 0 is in the MSBs.
- `TIMEOUT_CYC`, 24000: maximum idle clocks between payload bytes of a write command.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_valid`  in  1  one-cycle pulse: `rx_byte` is valid (UART `received`).
- `rx_byte`  in  8  received byte.
- `rx_error`  in  1  one-cycle pulse: UART framing error.
- `tx_busy`  in  1  UART `is_transmitting`.
- `tx_start`  out  1  one-cycle pulse: transmit `tx_byte`.
- `tx_byte`  out  8  byte to transmit; held stable from `tx_start` until the next `tx_start`.
- `state_in`  in  8*OUT_SIZE  live DDA state as `{x,y,z}`.
- `params`  out  8*REG_SIZE  committed parameter file; byte 0 is in the MSBs.
- `dda_en`  out  1  DDA step enable.
- `dda_init`  out  1  one-cycle pulse: DDA reloads its initial conditions.

## Operation
Reset values:
- `params` = `PARAM_INIT`; `dda_en` = 1.
- `tx_start` = 0, `tx_byte` = 0x00, `dda_init` = 0.
- Stream mode off; all pending flags clear; parser in IDLE.

Parser states: IDLE and PAYLOAD. It accepts one byte per `rx_valid` pulse.
- In IDLE, the command byte is decoded as follows:
  - 0x57 'W': go to PAYLOAD with the byte index cleared to 0.
  - 0x52 'R': `dda_en` <= 1; set ACK pending.
  - 0x53 'S': `dda_en` <= 0; set ACK pending.
  - 0x49 'I': pulse `dda_init` for one cycle; set ACK pending.
  - 0x44 'D': set DUMP pending.
  - 0x54 'T': toggle stream mode; set ACK pending.
  - Any other byte: set NAK pending.
- PAYLOAD:
  - Each byte is written to the shadow buffer at the current index, then the index increments.
  - When byte `REG_SIZE-1` is written, the full shadow buffer is copied to `params` on the next clock edge, ACK pending is set, and the parser returns to IDLE.
  - `params` never shows a partially written file.
- Abort from PAYLOAD:
  - Triggers: `rx_error`, or an idle counter reaching `TIMEOUT_CYC` with no `rx_valid`.
  - Action: discard the shadow buffer, leave `params` unchanged, set NAK pending, return to IDLE.
- `rx_error` in IDLE sets NAK pending only.

Transmit sequencer states: TX_IDLE, TX_SEND, TX_HOLD, TX_WAIT.
- Selection in TX_IDLE, highest priority first: NAK (single byte 0x15), ACK (single byte 0x06), then a frame.
  - A frame is sent when DUMP is pending or stream mode is on.
  - The pending flag is cleared when its transmission is selected.
  - NAK and ACK coexisting are both sent, NAK first.
- Frame format: 0xA5, followed by the `OUT_SIZE` bytes of `state_in`.
  - `state_in` is snapshotted in the cycle the frame is selected.
  - All bytes of one frame come from one DDA step.
- Per-byte handshake:
  - TX_SEND: `tx_byte` <= next byte and `tx_start` <= 1 for one cycle.
  - TX_HOLD: one cycle during which `tx_busy` is ignored.
  - TX_WAIT: wait until `tx_busy` = 0, then send the next byte or return to TX_IDLE.
- Stream mode re-selects a new frame immediately after each frame, subject to the same priority. ACK and NAK are therefore interleaved only at frame boundaries.
- The parser and transmit sequencer run concurrently. Commands received mid-frame are executed immediately; only their replies wait for the frame boundary.
- A pending flag set again before it is serviced is not duplicated.

## Timing
- Register effects of 'R', 'S', 'I' and 'T', and the `params` commit: visible on the clock edge after the `rx_valid` of the last byte.
- `dda_init` pulse: asserted on the clock edge after the 'I' byte's `rx_valid`, for one cycle.
- Reply start: `tx_start` is asserted at the earliest 2 cycles after the request, from TX_IDLE.
- Gap between bytes of a frame: at least 2 cycles after `tx_busy` falls.
- Timeout: the abort happens on the cycle the idle count reaches `TIMEOUT_CYC`; the count restarts on every payload byte.
- Reset mid-operation: all state returns to reset values. A frame in progress is truncated, and the UART finishes any byte already started.

## Test plan
- Reset, then idle: `params` = `PARAM_INIT`; `dda_en` = 1; no `tx_start`. Send 'D': bytes 0xA5 followed by the 6 `state_in` bytes captured at selection; `state_in` toggling mid-frame does not alter them.
- Send 'W' plus 14 bytes 0x01..0x0E: `params` changes only after the 14th byte, to `0x0102…0E`; 0x06 is transmitted.
- Send 'W' plus 5 bytes, then idle for `TIMEOUT_CYC` cycles: `params` is unchanged; 0x15 is transmitted. Repeat with `rx_error` after 3 bytes: same response.
- Send 'S', 'I', 'R': `dda_en` goes 1→0→1; `dda_init` is high for exactly one cycle; three 0x06 bytes are transmitted.
- Send 'T', then 0x7F mid-stream: frames are back-to-back. The 0x15 appears only between frames and before the next 0xA5. A second 'T' stops streaming after the current frame (its 0x06 is sent).
- Assert `rst` mid-frame: `tx_start` is 0 thereafter, stream mode is off, and `params` = `PARAM_INIT`.
